// File: rtl/hazard_sb.sv
// Hazard/forwarding unit for the 5-stage pipeline: per-source forward selects,
// divider busy sequencer, HI/LO and CP0 RAW interlocks, saturating stall counters.

module hazard_sb_src #(
  parameter int RA_W      = 5,
  parameter int BR_FWD_ES = 0
) (
  input  logic            used,
  input  logic [RA_W-1:0] src,
  input  logic            ds_is_branch,
  input  logic            es_valid,
  input  logic            es_gr_we,
  input  logic            es_res_from_mem,
  input  logic            es_res_from_cp0,
  input  logic [RA_W-1:0] es_dest,
  input  logic            ms_valid,
  input  logic            ms_gr_we,
  input  logic            ms_res_from_cp0,
  input  logic [RA_W-1:0] ms_dest,
  input  logic            ws_valid,
  input  logic            ws_gr_we,
  input  logic [RA_W-1:0] ws_dest,
  output logic [1:0]      fwd,
  output logic            stall
);
  logic live, es_hit, ms_hit, ws_hit, es_ok;

  assign live   = used && (src != '0);
  assign es_hit = live && es_valid && es_gr_we && (es_dest == src);
  assign ms_hit = live && ms_valid && ms_gr_we && (ms_dest == src);
  assign ws_hit = live && ws_valid && ws_gr_we && (ws_dest == src);
  // EX value is not ready for loads/mfc0, nor for branches unless the late path exists
  assign es_ok  = !es_res_from_mem && !es_res_from_cp0 && (!ds_is_branch || (BR_FWD_ES != 0));

  always_comb begin
    fwd   = 2'b00;
    stall = 1'b0;
    if (es_hit) begin
      fwd   = 2'b01;
      stall = !es_ok;
    end else if (ms_hit) begin
      fwd   = 2'b10;
      stall = ms_res_from_cp0;
    end else if (ws_hit) begin
      fwd   = 2'b11;
    end
  end
endmodule

module hazard_sb #(
  parameter int RA_W      = 5,
  parameter int DIV_LAT   = 32,
  parameter int BR_FWD_ES = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds_valid,
  input  logic             ds_is_branch,
  input  logic             ds_rd_hilo,
  input  logic             ds_rd_cp0,
  input  logic [RA_W-1:0]  ds_rs,
  input  logic [RA_W-1:0]  ds_rt,
  input  logic             ds_rs_used,
  input  logic             ds_rt_used,
  input  logic             es_valid,
  input  logic             es_gr_we,
  input  logic             es_res_from_mem,
  input  logic             es_res_from_cp0,
  input  logic             es_is_div,
  input  logic             es_wr_cp0,
  input  logic [RA_W-1:0]  es_dest,
  input  logic             es_go,
  input  logic             ms_valid,
  input  logic             ms_gr_we,
  input  logic             ms_res_from_cp0,
  input  logic             ms_wr_cp0,
  input  logic [RA_W-1:0]  ms_dest,
  input  logic             ws_valid,
  input  logic             ws_gr_we,
  input  logic             ws_wr_cp0,
  input  logic [RA_W-1:0]  ws_dest,
  input  logic             ws_flush,
  output logic [1:0]       ds_fwd_rs,
  output logic [1:0]       ds_fwd_rt,
  output logic             stall_d,
  output logic             stall_e,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_d_cnt,
  output logic [CNT_W-1:0] stall_e_cnt
);
  localparam int NSRC = 2;
  localparam int CW   = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_st_e;

  logic [NSRC-1:0][RA_W-1:0] src;
  logic [NSRC-1:0]           used;
  logic [NSRC-1:0][1:0]      fwd;
  logic [NSRC-1:0]           src_stall;

  assign src  = {ds_rt, ds_rs};
  assign used = {ds_rt_used, ds_rs_used};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_sb_src #(.RA_W(RA_W), .BR_FWD_ES(BR_FWD_ES)) u_src (
      .used(used[g]), .src(src[g]), .ds_is_branch(ds_is_branch),
      .es_valid(es_valid), .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
      .es_res_from_cp0(es_res_from_cp0), .es_dest(es_dest),
      .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_res_from_cp0(ms_res_from_cp0),
      .ms_dest(ms_dest), .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest),
      .fwd(fwd[g]), .stall(src_stall[g])
    );
  end

  div_st_e       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          es_div, div_active, hilo_hz, cp0_hz, quiet;

  assign es_div     = es_valid && es_is_div;
  assign div_active = (state != DIV_IDLE) || es_div;
  assign hilo_hz    = ds_rd_hilo && div_active;
  assign cp0_hz     = ds_rd_cp0 && ((es_valid && es_wr_cp0) || (ms_valid && ms_wr_cp0) ||
                                    (ws_valid && ws_wr_cp0));
  assign quiet      = reset || ws_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ws_flush) begin
      state_nxt = DIV_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        DIV_IDLE: if (es_div) begin
          state_nxt = DIV_BUSY;
          cnt_nxt   = CW'(DIV_LAT - 1);
        end
        DIV_BUSY: if (cnt == '0) state_nxt = DIV_DONE;
                  else           cnt_nxt   = cnt - 1'b1;
        DIV_DONE: if (es_go) state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  assign ds_fwd_rs = reset ? 2'b00 : fwd[0];
  assign ds_fwd_rt = reset ? 2'b00 : fwd[1];
  assign stall_d   = !quiet && ds_valid && ((|src_stall) || hilo_hz || cp0_hz);
  // the trigger cycle stalls too, so EX holds for DIV_LAT+1 cycles in total
  assign stall_e   = !quiet && (((state == DIV_IDLE) && es_div) || (state == DIV_BUSY));
  assign div_done  = !reset && (state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_d_cnt <= '0;
      stall_e_cnt <= '0;
    end else begin
      if (stall_d && (stall_d_cnt != {CNT_W{1'b1}})) stall_d_cnt <= stall_d_cnt + 1'b1;
      if (stall_e && (stall_e_cnt != {CNT_W{1'b1}})) stall_e_cnt <= stall_e_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: stimulus pushes expectations, a negedge monitor
// pops and compares. Second instance differs only in BR_FWD_ES=1.

module tb_hazard_sb;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic ds_valid, ds_is_branch, ds_rd_hilo, ds_rd_cp0, ds_rs_used, ds_rt_used;
  logic [RA_W-1:0] ds_rs, ds_rt, es_dest, ms_dest, ws_dest;
  logic es_valid, es_gr_we, es_res_from_mem, es_res_from_cp0, es_is_div, es_wr_cp0, es_go;
  logic ms_valid, ms_gr_we, ms_res_from_cp0, ms_wr_cp0;
  logic ws_valid, ws_gr_we, ws_wr_cp0, ws_flush;

  logic [1:0]  fwd_rs, fwd_rt, bf_fwd_rs, bf_fwd_rt;
  logic        stall_d, stall_e, div_done, bf_stall_d, bf_stall_e, bf_div_done;
  logic [2:0]  sd_cnt, se_cnt;
  logic [31:0] bf_sd_cnt, bf_se_cnt;

  always #5 clk = ~clk;

  hazard_sb #(.RA_W(RA_W), .DIV_LAT(4), .BR_FWD_ES(0), .CNT_W(3)) u_dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_is_branch(ds_is_branch),
    .ds_rd_hilo(ds_rd_hilo), .ds_rd_cp0(ds_rd_cp0), .ds_rs(ds_rs), .ds_rt(ds_rt),
    .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used), .es_valid(es_valid),
    .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_res_from_cp0(es_res_from_cp0),
    .es_is_div(es_is_div), .es_wr_cp0(es_wr_cp0), .es_dest(es_dest), .es_go(es_go),
    .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_res_from_cp0(ms_res_from_cp0),
    .ms_wr_cp0(ms_wr_cp0), .ms_dest(ms_dest), .ws_valid(ws_valid), .ws_gr_we(ws_gr_we),
    .ws_wr_cp0(ws_wr_cp0), .ws_dest(ws_dest), .ws_flush(ws_flush),
    .ds_fwd_rs(fwd_rs), .ds_fwd_rt(fwd_rt), .stall_d(stall_d), .stall_e(stall_e),
    .div_done(div_done), .stall_d_cnt(sd_cnt), .stall_e_cnt(se_cnt)
  );

  hazard_sb #(.RA_W(RA_W), .DIV_LAT(4), .BR_FWD_ES(1), .CNT_W(32)) u_dut_bf (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_is_branch(ds_is_branch),
    .ds_rd_hilo(ds_rd_hilo), .ds_rd_cp0(ds_rd_cp0), .ds_rs(ds_rs), .ds_rt(ds_rt),
    .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used), .es_valid(es_valid),
    .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_res_from_cp0(es_res_from_cp0),
    .es_is_div(es_is_div), .es_wr_cp0(es_wr_cp0), .es_dest(es_dest), .es_go(es_go),
    .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_res_from_cp0(ms_res_from_cp0),
    .ms_wr_cp0(ms_wr_cp0), .ms_dest(ms_dest), .ws_valid(ws_valid), .ws_gr_we(ws_gr_we),
    .ws_wr_cp0(ws_wr_cp0), .ws_dest(ws_dest), .ws_flush(ws_flush),
    .ds_fwd_rs(bf_fwd_rs), .ds_fwd_rt(bf_fwd_rt), .stall_d(bf_stall_d), .stall_e(bf_stall_e),
    .div_done(bf_div_done), .stall_d_cnt(bf_sd_cnt), .stall_e_cnt(bf_se_cnt)
  );

  typedef struct {
    string      nm;
    bit         is_cnt;
    logic [1:0] rs, rt;
    logic       sd, se, dd, bsd;
    logic [2:0] sdc, sec;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // monitor: outputs are combinational, so everything queued this cycle is checked at negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.is_cnt) begin
          cmp(e.nm, "stall_d_cnt", 32'(sd_cnt), 32'(e.sdc));
          cmp(e.nm, "stall_e_cnt", 32'(se_cnt), 32'(e.sec));
        end else begin
          cmp(e.nm, "fwd_rs", 32'(fwd_rs), 32'(e.rs));
          cmp(e.nm, "fwd_rt", 32'(fwd_rt), 32'(e.rt));
          cmp(e.nm, "stall_d", 32'(stall_d), 32'(e.sd));
          cmp(e.nm, "stall_e", 32'(stall_e), 32'(e.se));
          cmp(e.nm, "div_done", 32'(div_done), 32'(e.dd));
          cmp(e.nm, "bf_fwd_rs", 32'(bf_fwd_rs), 32'(e.rs));
          cmp(e.nm, "bf_stall_d", 32'(bf_stall_d), 32'(e.bsd));
        end
      end
    end
  end

  task automatic exp_out(input string nm, input logic [1:0] rs, input logic [1:0] rt,
                         input logic sd, input logic se, input logic dd, input logic bsd);
    exp_t e;
    e = '{nm: nm, is_cnt: 1'b0, rs: rs, rt: rt, sd: sd, se: se, dd: dd, bsd: bsd,
          sdc: 3'd0, sec: 3'd0};
    q.push_back(e);
  endtask

  task automatic exp_cnt(input string nm, input logic [2:0] sdc, input logic [2:0] sec);
    exp_t e;
    e = '{nm: nm, is_cnt: 1'b1, rs: 2'b00, rt: 2'b00, sd: 1'b0, se: 1'b0, dd: 1'b0, bsd: 1'b0,
          sdc: sdc, sec: sec};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ds_valid = 0; ds_is_branch = 0; ds_rd_hilo = 0; ds_rd_cp0 = 0;
    ds_rs = '0; ds_rt = '0; ds_rs_used = 0; ds_rt_used = 0;
    es_valid = 0; es_gr_we = 0; es_res_from_mem = 0; es_res_from_cp0 = 0;
    es_is_div = 0; es_wr_cp0 = 0; es_dest = '0; es_go = 0;
    ms_valid = 0; ms_gr_we = 0; ms_res_from_cp0 = 0; ms_wr_cp0 = 0; ms_dest = '0;
    ws_valid = 0; ws_gr_we = 0; ws_wr_cp0 = 0; ws_dest = '0; ws_flush = 0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    tick();
    // reset state: hazards and a div present, but everything must read zero
    ds_valid = 1; ds_rs = 5'd8; ds_rs_used = 1; ds_rd_hilo = 1;
    es_valid = 1; es_gr_we = 1; es_dest = 5'd8; es_is_div = 1;
    exp_out("reset", 2'b00, 2'b00, 0, 0, 0, 0);
    exp_cnt("reset_cnt", 3'd0, 3'd0);
    tick();
    do_reset();

    // EX ALU forward, then load-use stall, then MEM forward
    ds_valid = 1; ds_rs = 5'd8; ds_rs_used = 1;
    es_valid = 1; es_gr_we = 1; es_dest = 5'd8;
    exp_out("ex_fwd", 2'b01, 2'b00, 0, 0, 0, 0);
    tick();
    es_res_from_mem = 1;
    exp_out("load_use", 2'b01, 2'b00, 1, 0, 0, 1);
    tick();
    es_valid = 0; es_gr_we = 0; es_res_from_mem = 0;
    ms_valid = 1; ms_gr_we = 1; ms_dest = 5'd8;
    exp_out("mem_fwd", 2'b10, 2'b00, 0, 0, 0, 0);
    exp_cnt("load_use_cnt", 3'd1, 3'd0);
    tick();

    // priority: all three write r9
    clr();
    ds_valid = 1; ds_rt = 5'd9; ds_rt_used = 1;
    es_valid = 1; es_gr_we = 1; es_dest = 5'd9;
    ms_valid = 1; ms_gr_we = 1; ms_dest = 5'd9;
    ws_valid = 1; ws_gr_we = 1; ws_dest = 5'd9;
    exp_out("prio_ex", 2'b00, 2'b01, 0, 0, 0, 0);
    tick();
    ds_rt = 5'd0;
    exp_out("r0_nofwd", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    ds_rt = 5'd9; es_valid = 0;
    exp_out("prio_mem", 2'b00, 2'b10, 0, 0, 0, 0);
    tick();
    ms_valid = 0;
    exp_out("wb_fwd", 2'b00, 2'b11, 0, 0, 0, 0);
    tick();
    ms_valid = 1; ms_res_from_cp0 = 1;
    exp_out("mfc0_mem", 2'b00, 2'b10, 1, 0, 0, 1);
    tick();

    // branch on EX ALU result: stalls only without the late branch path
    clr();
    ds_valid = 1; ds_is_branch = 1; ds_rs = 5'd4; ds_rs_used = 1;
    es_valid = 1; es_gr_we = 1; es_dest = 5'd4;
    exp_out("br_ex", 2'b01, 2'b00, 1, 0, 0, 0);
    exp_cnt("pre_br_cnt", 3'd2, 3'd0);
    tick();
    exp_cnt("post_br_cnt", 3'd3, 3'd0);
    tick();

    // divider, DIV_LAT=4, with mfhi waiting in ID
    do_reset();
    es_valid = 1; es_is_div = 1; ds_valid = 1; ds_rd_hilo = 1;
    for (int i = 0; i < 5; i++) begin
      exp_out($sformatf("div_busy%0d", i), 2'b00, 2'b00, 1, 1, 0, 1);
      tick();
    end
    exp_out("div_done", 2'b00, 2'b00, 1, 0, 1, 1);
    exp_cnt("div_cnt", 3'd5, 3'd5);
    tick();
    exp_out("div_hold", 2'b00, 2'b00, 1, 0, 1, 1);
    tick();
    es_go = 1;
    exp_out("div_go", 2'b00, 2'b00, 1, 0, 1, 1);
    exp_cnt("div_go_cnt", 3'd7, 3'd5);
    tick();
    es_go = 0; es_valid = 0; es_is_div = 0;
    exp_out("div_idle", 2'b00, 2'b00, 0, 0, 0, 0);
    exp_cnt("div_sat_cnt", 3'd7, 3'd5);
    tick();

    // flush in BUSY with cnt=2
    do_reset();
    es_valid = 1; es_is_div = 1;
    tick();
    tick();
    ws_flush = 1; ds_valid = 1; ds_rd_hilo = 1;
    exp_out("flush_cyc", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    ws_flush = 0; es_valid = 0; es_is_div = 0;
    exp_out("flush_idle", 2'b00, 2'b00, 0, 0, 0, 0);
    exp_cnt("flush_cnt", 3'd0, 3'd2);
    tick();

    // same abort via reset, with a forwardable source present
    do_reset();
    es_valid = 1; es_is_div = 1; es_gr_we = 1; es_dest = 5'd3;
    tick();
    tick();
    reset = 1; ds_valid = 1; ds_rd_hilo = 1; ds_rs = 5'd3; ds_rs_used = 1;
    exp_out("rst_mid", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    reset = 0; es_valid = 0; es_is_div = 0;
    exp_out("rst_idle", 2'b00, 2'b00, 0, 0, 0, 0);
    exp_cnt("rst_cnt", 3'd0, 3'd0);
    tick();

    // mfc0 behind mtc0: saturating counter, stall until mtc0 leaves WB
    do_reset();
    ds_valid = 1; ds_rd_cp0 = 1; ms_valid = 1; ms_wr_cp0 = 1;
    for (int i = 0; i < 10; i++) begin
      exp_out($sformatf("cp0_ms%0d", i), 2'b00, 2'b00, 1, 0, 0, 1);
      exp_cnt($sformatf("sat%0d", i), (i > 7) ? 3'd7 : 3'(i), 3'd0);
      tick();
    end
    ms_valid = 0; ms_wr_cp0 = 0; ws_valid = 1; ws_wr_cp0 = 1;
    exp_out("cp0_ws", 2'b00, 2'b00, 1, 0, 0, 1);
    tick();
    ws_valid = 0; ws_wr_cp0 = 0;
    exp_out("cp0_clear", 2'b00, 2'b00, 0, 0, 0, 0);
    exp_cnt("sat_end", 3'd7, 3'd0);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
